multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore-style main control FSM for the multi-cycle variant of the MIPS core.
- Replaces the single-cycle combinational control unit: sequences one shared instruction/data memory, one ALU and the PC over 3–5 cycles per instruction.
- Adds a memory ready handshake with a watchdog timeout.
- Sits between the instruction register opcode field and the datapath mux selects and write enables.

Parameters:
- TIMEOUT, 16, maximum cycles a memory state waits for mem_ready before aborting (≥2).
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instruction register bits [31:26].
- mem_ready  in  1  shared memory has completed the current read or write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- pc_source  out  2  next-PC select: 00 ALU result, 01 ALU-out register, 10 jump address.
- i_or_d  out  1  memory address select: 0 PC, 1 ALU-out.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  write-register select: 0 rt, 1 rd.
- mem_to_reg  out  1  write-back select: 0 ALU-out, 1 memory data register.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 PC, 1 rs.
- alu_src_b  out  2  ALU B select: 00 rt, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate <<2.
- alu_op  out  2  to alu_control: 00 add, 01 sub, 10 funct.
- instr_done  out  1  one-cycle pulse in the final cycle of each retired instruction.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- bus_error  out  1  one-cycle pulse on memory timeout.
- state  out  4  current state, for debug.

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEM_ADR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11.
  - Codes 12–15 are unreachable; they go to FETCH on the next edge with all strobes 0.
- Reset:
  - While rst is high at a clock edge: state←FETCH, wait counter←0.
  - During any cycle with rst high, mem_read, mem_write, ir_write, pc_write, pc_write_cond, reg_write, instr_done, illegal_op and bus_error are all 0.
  - rst mid-instruction abandons it; no register or memory write occurs after the edge.
- Default for every output is 0 unless listed for the state below.
- FETCH:
  - mem_read=1, alu_src_b=01.
  - ir_write=pc_write=mem_ready (Mealy).
  - Next state: DECODE if mem_ready, else stay.
- DECODE:
  - alu_src_b=11.
  - Opcode dispatch: 000000→EXECUTE, 100011 (lw) or 101011 (sw)→MEM_ADR, 000100 (beq)→BRANCH, 000010 (j)→JUMP, 001000 (addi)→ADDI_EX.
  - Any other opcode: illegal_op=1, next state FETCH.
- MEM_ADR:
  - alu_src_a=1, alu_src_b=10.
  - Next state: lw→MEM_READ, sw→MEM_WRITE (opcode is held stable by the IR).
- MEM_READ:
  - mem_read=1, i_or_d=1.
  - Next state: MEM_WB if mem_ready, else stay.
- MEM_WB:
  - reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1.
  - Next state: FETCH.
- MEM_WRITE:
  - mem_write=1, i_or_d=1.
  - instr_done=mem_ready.
  - Next state: FETCH if mem_ready, else stay.
- EXECUTE:
  - alu_src_a=1, alu_src_b=00, alu_op=10.
  - Next state: ALU_WB.
- ALU_WB:
  - reg_write=1, reg_dst=1, instr_done=1.
  - Next state: FETCH.
- BRANCH:
  - alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1.
  - Next state: FETCH.
- JUMP:
  - pc_write=1, pc_source=10, instr_done=1.
  - Next state: FETCH.
- ADDI_EX:
  - alu_src_a=1, alu_src_b=10.
  - Next state: ADDI_WB.
- ADDI_WB:
  - reg_write=1, reg_dst=0, instr_done=1.
  - Next state: FETCH.
- Wait counter (applies only in FETCH, MEM_READ and MEM_WRITE):
  - Increments each cycle mem_ready is 0; clears on mem_ready=1 or on any state change.
  - When the counter equals TIMEOUT−1 and mem_ready is 0: bus_error=1 that cycle, counter←0, next state FETCH.
  - The aborted instruction gets no instr_done.
  - A FETCH timeout re-enters FETCH, i.e. retries the fetch with the PC unchanged.
  - If mem_ready=1 arrives in the timeout cycle, it wins: normal completion, no bus_error.
- Cycle latency with mem_ready tied to 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
- illegal_op, bus_error and instr_done are never asserted in the same cycle.

Test Plan:
- rst held 3 cycles then released, mem_ready=1, opcode=000000 → state sequence 0,1,6,7,0; reg_write=1 only in cycle 4 with reg_dst=1; instr_done pulses exactly once.
- lw (100011), mem_ready=1 → states 0,1,2,3,4; mem_read=1 with i_or_d=1 in state 3; reg_write=1 and mem_to_reg=1 in state 4. Repeat with mem_ready low for 3 cycles in MEM_READ → 8 total cycles, still no bus_error.
- sw (101011), mem_ready delayed 2 cycles in MEM_WRITE → mem_write held for 3 cycles; instr_done coincides with mem_ready; reg_write never asserted.
- beq (000100) and j (000010) → 3 cycles each; BRANCH drives pc_write_cond=1, pc_source=01, alu_op=01; JUMP drives pc_write=1, pc_source=10.
- TIMEOUT=16, mem_ready=0 throughout FETCH → bus_error pulses on the 16th cycle, state stays 0, ir_write never asserted. Same in MEM_READ → return to FETCH, no reg_write, no instr_done.
- opcode=111111 → illegal_op pulse in DECODE, then FETCH; no write strobes. Separately, rst asserted during MEM_WRITE → mem_write=0 in that cycle, state=0 after the edge.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS main control FSM: sequences the shared memory, the ALU
// and the PC over 3-5 cycles per instruction. A watchdog bounds how long
// each memory state waits for mem_ready.
module multicycle_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    ALU_WB    = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EX   = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           cur;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             waiting;
  logic             timeout;

  assign state = cur;

  // State register and watchdog counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= FETCH;
      cnt <= '0;
    end else begin
      cur <= nxt;
      cnt <= cnt_n;
    end
  end

  // Next state, watchdog and datapath controls for the current state.
  always_comb begin
    nxt           = FETCH;
    cnt_n         = '0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    bus_error     = 1'b0;

    waiting = (cur == FETCH) || (cur == MEM_READ) || (cur == MEM_WRITE);
    timeout = waiting && !mem_ready && (cnt == CNT_LAST);
    if (waiting && !mem_ready && !timeout) begin
      cnt_n = cnt + 1'b1;
    end

    case (cur)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        nxt       = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:     nxt = EXECUTE;
          OP_LW, OP_SW: nxt = MEM_ADR;
          OP_BEQ:       nxt = BRANCH;
          OP_J:         nxt = JUMP;
          OP_ADDI:      nxt = ADDI_EX;
          default: begin
            illegal_op = 1'b1;
            nxt        = FETCH;
          end
        endcase
      end
      MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW)      nxt = MEM_READ;
        else if (opcode == OP_SW) nxt = MEM_WRITE;
        else                      nxt = FETCH;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        nxt      = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        nxt        = mem_ready ? FETCH : MEM_WRITE;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nxt       = ALU_WB;
      end
      ALU_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        nxt = FETCH;
      end
    endcase

    // Timeout overrides the wait: abort to FETCH with no completion pulse.
    if (timeout) begin
      bus_error = 1'b1;
      nxt       = FETCH;
    end

    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      bus_error     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: an instruction-path model
// (per-opcode state lists plus a wait budget) predicts every output each
// cycle; directed scenarios pin the model with literal expectations.
module tb_multicycle_controller;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'b000000;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic       instr_done, illegal_op, bus_error;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state;

  multicycle_controller #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .instr_done(instr_done), .illegal_op(illegal_op),
    .bus_error(bus_error), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Instruction paths as lists of state codes, one per opcode class.
  int path [6][5] = '{'{0, 1, 6, 7, 0}, '{0, 1, 2, 3, 4}, '{0, 1, 2, 5, 0},
                      '{0, 1, 8, 0, 0}, '{0, 1, 9, 0, 0}, '{0, 1, 10, 11, 0}};
  int plen [6] = '{4, 5, 4, 3, 3, 4};

  int m_pos = 0;
  int m_wait = 0;

  // Observations of the most recent cycle, for directed checks.
  int obs_state, obs_done, obs_ill, obs_bus, obs_ir, obs_rw, obs_mw;

  function automatic int kind_of(logic [5:0] op);
    case (op)
      6'b000000: return 0;
      6'b100011: return 1;
      6'b101011: return 2;
      6'b000100: return 3;
      6'b000010: return 4;
      6'b001000: return 5;
      default:   return -1;
    endcase
  endfunction

  // Vector order: pc_write, pc_write_cond, pc_source, i_or_d, mem_read,
  // mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
  // alu_src_b, alu_op, instr_done, illegal_op, bus_error, state.
  function automatic logic [22:0] exp_for(int code, logic rdy, logic r,
                                          logic done, logic ill, logic bus);
    logic       pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, ir = 0;
    logic       rdst = 0, m2r = 0, rw = 0, asa = 0;
    logic [1:0] psrc = 0, asb = 0, aop = 0;
    case (code)
      0:  begin mr = 1; asb = 2'b01; ir = rdy; pcw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      9:  begin pcw = 1; psrc = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    if (r) begin
      pcw = 0; pcwc = 0; mr = 0; mw = 0; ir = 0; rw = 0;
    end
    return {pcw, pcwc, psrc, iord, mr, mw, ir, rdst, m2r, rw, asa, asb, aop,
            done, ill, bus, 4'(code)};
  endfunction

  task automatic check_eq(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive, compare against the model, then advance it.
  task automatic run_cycle(input logic r, input logic rdy, input logic [5:0] op);
    int k, code;
    logic waiting, last, e_done, e_ill, e_bus;
    logic [22:0] exp_v, dut_v, mask;
    @(negedge clk);
    rst = r; mem_ready = rdy; opcode = op;
    #1;
    k = kind_of(op);
    code = (m_pos < 2) ? m_pos : path[k][m_pos];
    waiting = (code == 0) || (code == 3) || (code == 5);
    last = (k >= 0) && (m_pos == plen[k] - 1);
    e_bus = !r && waiting && !rdy && (m_wait == TIMEOUT - 1);
    e_ill = !r && (m_pos == 1) && (k < 0);
    e_done = !r && last && (!waiting || rdy);
    exp_v = exp_for(code, rdy, r, e_done, e_ill, e_bus);
    dut_v = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
             ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
             alu_op, instr_done, illegal_op, bus_error, state};
    // Mux selects are don't-care while reset is asserted.
    mask = r ? {2'b11, 2'b00, 1'b0, 3'b111, 2'b00, 1'b1, 1'b0, 4'b0000, 3'b111, 4'hF}
             : '1;
    checks++;
    if (((dut_v ^ exp_v) & mask) != '0) begin
      failures++;
      $display("FAIL outputs cycle %0d: got %06h expected %06h (mask %06h)",
               cyc, dut_v, exp_v, mask);
    end
    obs_state = int'(state); obs_done = int'(instr_done); obs_ill = int'(illegal_op);
    obs_bus = int'(bus_error); obs_ir = int'(ir_write); obs_rw = int'(reg_write);
    obs_mw = int'(mem_write);
    @(posedge clk);
    cyc++;
    if (r) begin
      m_pos = 0; m_wait = 0;
    end else if (waiting) begin
      if (rdy) begin
        m_wait = 0;
        m_pos = last ? 0 : m_pos + 1;
      end else if (m_wait == TIMEOUT - 1) begin
        m_pos = 0; m_wait = 0;
      end else begin
        m_wait++;
      end
    end else if (m_pos == 1 && k < 0) begin
      m_pos = 0;
    end else begin
      m_pos = last ? 0 : m_pos + 1;
    end
  endtask

  task automatic do_reset();
    run_cycle(1'b1, 1'b1, 6'b000000);
  endtask

  initial begin
    int trace [5];
    int lit_rt [5] = '{0, 1, 6, 7, 0};
    int cnt_a, cnt_b, at;
    logic [5:0] ops [6] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08};
    logic [5:0] bad [4] = '{6'h3f, 6'h01, 6'h0f, 6'h22};
    logic [5:0] op;
    int mode;

    // Reset held 3 cycles, then an R-type with memory always ready.
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, 6'h00);
    check_eq("reset_state", obs_state, 0);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b0, 1'b1, 6'h00);
      trace[i] = obs_state;
      if (i < 4) begin
        cnt_a += obs_done;
        if (obs_rw == 1) cnt_b = i;
      end
    end
    for (int i = 0; i < 5; i++) check_eq("rtype_state_seq", trace[i], lit_rt[i]);
    check_eq("rtype_done_count", cnt_a, 1);
    check_eq("rtype_regwrite_cycle", cnt_b, 3);

    // lw with MEM_READ stalled 3 cycles: 8 cycles, no bus error.
    do_reset();
    at = -1; cnt_a = 0;
    for (int i = 0; i < 8; i++) begin
      run_cycle(1'b0, !(i >= 3 && i <= 5), 6'b100011);
      if (obs_done == 1) at = i;
      cnt_a += obs_bus;
    end
    check_eq("lw_stall_done_cycle", at, 7);
    check_eq("lw_stall_bus_error", cnt_a, 0);
    check_eq("lw_stall_last_state", obs_state, 4);

    // sw with mem_ready delayed 2 cycles in MEM_WRITE.
    do_reset();
    at = -1; cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b0, !(i == 3 || i == 4), 6'b101011);
      cnt_a += obs_mw;
      cnt_b += obs_rw;
      if (obs_done == 1) at = i;
    end
    check_eq("sw_memwrite_cycles", cnt_a, 3);
    check_eq("sw_done_cycle", at, 5);
    check_eq("sw_regwrite_count", cnt_b, 0);

    // beq and j retire in 3 cycles.
    do_reset();
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 6'b000100);
    check_eq("beq_last_state", obs_state, 8);
    check_eq("beq_done", obs_done, 1);
    do_reset();
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 6'b000010);
    check_eq("j_last_state", obs_state, 9);
    check_eq("j_done", obs_done, 1);

    // FETCH timeout: bus error on the 16th waiting cycle, fetch retried.
    do_reset();
    at = -1; cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 17; i++) begin
      run_cycle(1'b0, 1'b0, 6'h00);
      if (obs_bus == 1 && at < 0) at = i;
      cnt_a += obs_ir;
      if (obs_state != 0) cnt_b++;
    end
    check_eq("fetch_timeout_cycle", at, 15);
    check_eq("fetch_timeout_ir_write", cnt_a, 0);
    check_eq("fetch_timeout_state_moves", cnt_b, 0);

    // MEM_READ timeout: back to FETCH, no write-back, no completion.
    do_reset();
    at = -1; cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      run_cycle(1'b0, i < 3, 6'b100011);
      if (obs_bus == 1) at = i;
      cnt_a += obs_rw;
      cnt_b += obs_done;
    end
    check_eq("memread_timeout_cycle", at, 18);
    check_eq("memread_timeout_regwrite", cnt_a, 0);
    check_eq("memread_timeout_done", cnt_b, 0);
    check_eq("memread_timeout_state", obs_state, 0);

    // Illegal opcode flagged in DECODE, then back to FETCH.
    do_reset();
    run_cycle(1'b0, 1'b1, 6'b111111);
    run_cycle(1'b0, 1'b1, 6'b111111);
    check_eq("illegal_pulse", obs_ill, 1);
    run_cycle(1'b0, 1'b1, 6'b111111);
    check_eq("illegal_next_state", obs_state, 0);

    // Reset asserted while sitting in MEM_WRITE.
    do_reset();
    for (int i = 0; i < 4; i++) run_cycle(1'b0, i < 3, 6'b101011);
    check_eq("sw_in_memwrite", obs_state, 5);
    run_cycle(1'b1, 1'b1, 6'b101011);
    check_eq("rst_memwrite_strobe", obs_mw, 0);
    run_cycle(1'b0, 1'b0, 6'b101011);
    check_eq("rst_memwrite_after", obs_state, 0);

    // Randomized traffic: mixed opcodes, ready patterns and resets.
    do_reset();
    op = 6'h00;
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) mode = int'($urandom_range(0, 2));
      if (m_pos == 0) begin
        if ($urandom_range(0, 7) == 0) op = bad[$urandom_range(0, 3)];
        else                           op = ops[$urandom_range(0, 5)];
      end
      case (mode)
        0:       run_cycle($urandom_range(0, 99) == 0, 1'b1, op);
        1:       run_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, op);
        default: run_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0, op);
      endcase
      if (m_pos != 0 && rst == 1'b1) op = op;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
